// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit memory, redirect and decoder-side signal bundle
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner issuing single-outstanding imem fetches into a small instruction FIFO
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);
    localparam int              PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  DEPTH = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [31:0]     NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t            state, state_n;
    logic [31:0]       pc, pc_n;
    logic [31:0]       mem_instr [FIFO_DEPTH];
    logic [31:0]       mem_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_n;
    logic [PTR_W:0]    count, count_left, count_n;
    logic              push, pop, issue;
    logic [31:0]       head_instr, head_pc;

    always_comb begin
        pop        = bus.instr_valid && bus.instr_ready;
        push       = (state == WAIT) && bus.imem_ack && !bus.redirect;
        count_left = count - (PTR_W+1)'(pop);
        count_n    = bus.redirect ? '0 : count_left + (PTR_W+1)'(push);
        rd_ptr_n   = rd_ptr + PTR_W'(pop);

        pc_n = pc;
        if (bus.redirect)
            pc_n = {bus.redirect_pc[31:2], 2'b00};
        else if (push)
            pc_n = pc + 32'd4;

        // A redirect can start the new fetch at once unless a request is still
        // in flight without its ack; that one has to drain through DROP first.
        issue   = 1'b0;
        state_n = state;
        if (bus.redirect) begin
            if (state == IDLE || bus.imem_ack)
                issue = 1'b1;
            else
                state_n = DROP;
        end else begin
            case (state)
                IDLE:    issue = (count_n < DEPTH);
                WAIT:    if (bus.imem_ack) begin
                             issue   = (count_n < DEPTH);
                             state_n = IDLE;
                         end
                DROP:    if (bus.imem_ack) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
        if (issue)
            state_n = WAIT;

        // Entry that will sit at the head after this cycle's push/pop.
        if (count_n == '0) begin
            head_instr = NOP;
            head_pc    = 32'h0;
        end else if (count_left == '0) begin
            head_instr = bus.imem_rdata;
            head_pc    = pc;
        end else begin
            head_instr = mem_instr[rd_ptr_n];
            head_pc    = mem_pc[rd_ptr_n];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= bus.imem_rdata;
            mem_pc[wr_ptr]    <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            pc              <= RESET_PC;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            bus.imem_req    <= 1'b0;
            bus.imem_addr   <= RESET_PC;
            bus.instr_valid <= 1'b0;
            bus.instr       <= NOP;
            bus.instr_pc    <= 32'h0;
        end else begin
            state           <= state_n;
            pc              <= pc_n;
            count           <= count_n;
            bus.imem_req    <= (state_n != IDLE);
            if (issue)
                bus.imem_addr <= pc_n;
            if (bus.redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                wr_ptr <= wr_ptr + PTR_W'(push);
                rd_ptr <= rd_ptr_n;
            end
            bus.instr_valid <= (count_n != '0);
            bus.instr       <= head_instr;
            bus.instr_pc    <= head_pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset;
    logic reset2;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fetch_unit_if bus();
    fetch_unit_if bus2();

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_wrap (
        .clk(clk), .reset(reset2), .bus(bus2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    always @(negedge clk) begin
        if (!reset) begin
            chk("addr_align", {30'h0, bus.imem_addr[1:0]}, 32'h0);
            chk("addr_align_wrap", {30'h0, bus2.imem_addr[1:0]}, 32'h0);
            if (prev_hold)
                chk("addr_stable", bus.imem_addr, prev_addr);
            chk("count_bound", {31'h0, (dut.count > 2'(2))}, 32'h0);
        end
        prev_hold = !reset && bus.imem_req && !bus.imem_ack;
        prev_addr = bus.imem_addr;
    end

    initial begin
        reset = 1'b1;
        reset2 = 1'b1;
        bus.imem_ack = 1'b0;   bus.imem_rdata = 32'h0;
        bus.redirect = 1'b0;   bus.redirect_pc = 32'h0;
        bus.instr_ready = 1'b0;
        bus2.imem_ack = 1'b0;  bus2.imem_rdata = 32'h0;
        bus2.redirect = 1'b0;  bus2.redirect_pc = 32'h0;
        bus2.instr_ready = 1'b0;
        tick(); tick();

        chk("rst_req", {31'h0, bus.imem_req}, 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_valid", {31'h0, bus.instr_valid}, 32'h0);
        chk("rst_instr", bus.instr, 32'h13);
        chk("rst_pc", bus.instr_pc, 32'h0);
        chk("rst_wrap_addr", bus2.imem_addr, 32'hFFFF_FFFC);

        // Streaming: ack every cycle, decoder always ready.
        reset = 1'b0;
        bus.instr_ready = 1'b1;
        tick();
        chk("s_req0", {31'h0, bus.imem_req}, 32'h1);
        chk("s_addr0", bus.imem_addr, 32'h0);
        chk("s_valid0", {31'h0, bus.instr_valid}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            bus.imem_ack = 1'b1;
            bus.imem_rdata = 32'h1000_0000 + 32'(i);
            tick();
            chk("s_valid", {31'h0, bus.instr_valid}, 32'h1);
            chk("s_instr", bus.instr, 32'h1000_0000 + 32'(i));
            chk("s_pc", bus.instr_pc, 32'(4 * i));
            chk("s_addr", bus.imem_addr, 32'(4 * (i + 1)));
        end

        // Reset during WAIT with one entry buffered.
        bus.imem_ack = 1'b0;
        bus.instr_ready = 1'b0;
        reset = 1'b1;
        tick();
        chk("mr_valid", {31'h0, bus.instr_valid}, 32'h0);
        chk("mr_req", {31'h0, bus.imem_req}, 32'h0);
        chk("mr_instr", bus.instr, 32'h13);

        // Backpressure: decoder stalled, ack one cycle after each request.
        reset = 1'b0;
        tick();
        chk("b_req0", {31'h0, bus.imem_req}, 32'h1);
        chk("b_addr0", bus.imem_addr, 32'h0);
        tick();
        chk("b_hold0", bus.imem_addr, 32'h0);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hB000_0000;
        tick();
        chk("b_valid", {31'h0, bus.instr_valid}, 32'h1);
        chk("b_instr0", bus.instr, 32'hB000_0000);
        chk("b_addr1", bus.imem_addr, 32'h4);
        bus.imem_ack = 1'b0;
        tick();
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hB000_0001;
        tick();
        chk("b_full_req", {31'h0, bus.imem_req}, 32'h0);
        chk("b_head_keep", bus.instr, 32'hB000_0000);
        bus.imem_ack = 1'b0;
        tick();
        chk("b_full_idle", {31'h0, bus.imem_req}, 32'h0);
        bus.instr_ready = 1'b1;
        tick();
        chk("b_pop_instr", bus.instr, 32'hB000_0001);
        chk("b_pop_pc", bus.instr_pc, 32'h4);
        chk("b_req8", {31'h0, bus.imem_req}, 32'h1);
        chk("b_addr8", bus.imem_addr, 32'h8);
        bus.instr_ready = 1'b0;

        // Redirect while waiting: stale request drains through DROP.
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0102;
        tick();
        bus.redirect = 1'b0;
        chk("d_flush", {31'h0, bus.instr_valid}, 32'h0);
        chk("d_nop", bus.instr, 32'h13);
        chk("d_stale_addr", bus.imem_addr, 32'h8);
        chk("d_req_held", {31'h0, bus.imem_req}, 32'h1);
        tick(); tick();
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.imem_ack = 1'b0;
        chk("d_req_idle", {31'h0, bus.imem_req}, 32'h0);
        chk("d_no_beef", bus.instr, 32'h13);
        tick();
        chk("d_new_req", {31'h0, bus.imem_req}, 32'h1);
        chk("d_new_addr", bus.imem_addr, 32'h100);
        chk("d_empty", {31'h0, bus.instr_valid}, 32'h0);

        // Redirect in the same cycle as ack: data discarded, no DROP.
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hCAFE_0000;
        bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
        tick();
        bus.redirect = 1'b0;
        chk("r_req", {31'h0, bus.imem_req}, 32'h1);
        chk("r_addr", bus.imem_addr, 32'h200);
        chk("r_discard", bus.instr, 32'h13);
        bus.imem_rdata = 32'h2222_2222;
        tick();
        bus.imem_ack = 1'b0;
        chk("r_instr", bus.instr, 32'h2222_2222);
        chk("r_pc", bus.instr_pc, 32'h200);
        chk("r_next", bus.imem_addr, 32'h204);

        // PC wrap from RESET_PC = 0xFFFF_FFFC.
        reset2 = 1'b0;
        tick();
        chk("w_addr0", bus2.imem_addr, 32'hFFFF_FFFC);
        bus2.imem_ack = 1'b1; bus2.imem_rdata = 32'h0000_0077;
        tick();
        bus2.imem_ack = 1'b0;
        chk("w_pc", bus2.instr_pc, 32'hFFFF_FFFC);
        chk("w_instr", bus2.instr, 32'h77);
        chk("w_addr1", bus2.imem_addr, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
